// File: rtl/lsu_dmem_port_pkg.sv
`default_nettype none
// ============================================================
// Module : lsu_dmem_port_pkg
// Brief  : Shared encodings, FSM states and access legality.
// Rev    : 1.0
// ============================================================
package lsu_dmem_port_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] WSTRB_NONE = 4'b0000;
  localparam logic [3:0] WSTRB_B    = 4'b0001;
  localparam logic [3:0] WSTRB_H    = 4'b0011;
  localparam logic [3:0] WSTRB_W    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Unsigned sizes exist only for loads; halves and words must be naturally aligned.
  function automatic logic is_illegal(input logic we, input logic [2:0] funct3,
                                      input logic [1:0] lane);
    logic ill;
    case (funct3)
      F3_LB:   ill = 1'b0;
      F3_LH:   ill = lane[0];
      F3_LW:   ill = |lane;
      F3_LBU:  ill = we;
      F3_LHU:  ill = we | lane[0];
      default: ill = 1'b1;
    endcase
    return ill;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_dmem_port_load_extend.sv
`default_nettype none
// ============================================================
// Module : lsu_dmem_port_load_extend
// Brief  : Selects a byte/half/word lane from a bus word and extends it.
// Rev    : 1.0
// ============================================================
module lsu_dmem_port_load_extend
  import lsu_dmem_port_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      lane,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = rdata[{lane, 3'b000} +: 8];
  assign w_half = lane[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = '0;
    case (funct3)
      F3_LB:   data = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  data = {24'd0, w_byte};
      F3_LH:   data = {{16{w_half[15]}}, w_half};
      F3_LHU:  data = {16'd0, w_half};
      F3_LW:   data = rdata;
      default: data = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_dmem_port.sv
`default_nettype none
// ============================================================
// Module : lsu_dmem_port
// Brief  : Single-outstanding load/store back end to the data-memory bus.
// Rev    : 1.0
// ============================================================
module lsu_dmem_port
  import lsu_dmem_port_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_resp_err,
  output logic            done_valid,
  output logic [XLEN-1:0] dmem_data,
  output logic            misalign,
  output logic            bus_err
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_we;
  logic [2:0]      r_funct3;
  logic [1:0]      r_lane;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [3:0]      r_wstrb;
  logic [XLEN-1:0] r_dmem_data;
  logic            r_misalign;
  logic            r_bus_err;

  logic            w_illegal;
  logic            w_accept;
  logic            w_resp;
  logic [XLEN-1:0] w_st_data;
  logic [3:0]      w_st_strb;
  logic [XLEN-1:0] w_load_data;

  assign w_illegal = is_illegal(req_we, req_funct3, req_addr[1:0]);
  assign w_accept  = (r_state == ST_IDLE) && req_valid;
  assign w_resp    = (r_state == ST_WAIT) && mem_resp_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    done_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = w_illegal ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_resp_valid) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done_valid  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Store lanes are replicated so the bus can pick any lane under the strobes.
  always_comb begin
    w_st_data = '0;
    w_st_strb = WSTRB_NONE;
    if (req_we && !w_illegal) begin
      case (req_funct3)
        F3_SB: begin
          w_st_data = {4{req_wdata[7:0]}};
          w_st_strb = WSTRB_B << req_addr[1:0];
        end
        F3_SH: begin
          w_st_data = {2{req_wdata[15:0]}};
          w_st_strb = WSTRB_H << req_addr[1:0];
        end
        default: begin
          w_st_data = req_wdata;
          w_st_strb = WSTRB_W;
        end
      endcase
    end
  end

  lsu_dmem_port_load_extend u_load_extend (
    .rdata  (mem_rdata),
    .lane   (r_lane),
    .funct3 (r_funct3),
    .data   (w_load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we        <= 1'b0;
      r_funct3    <= 3'd0;
      r_lane      <= 2'd0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= WSTRB_NONE;
      r_dmem_data <= '0;
      r_misalign  <= 1'b0;
      r_bus_err   <= 1'b0;
    end else if (w_accept) begin
      r_we        <= req_we;
      r_funct3    <= req_funct3;
      r_lane      <= req_addr[1:0];
      r_addr      <= {req_addr[XLEN-1:2], 2'b00};
      r_wdata     <= w_st_data;
      r_wstrb     <= w_st_strb;
      r_dmem_data <= '0;
      r_misalign  <= w_illegal;
      r_bus_err   <= 1'b0;
    end else if (w_resp) begin
      r_bus_err   <= mem_resp_err;
      r_dmem_data <= (mem_resp_err || r_we) ? '0 : w_load_data;
    end
  end

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wstrb = r_wstrb;
  assign dmem_data = r_dmem_data;
  assign misalign  = r_misalign;
  assign bus_err   = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_lsu_dmem_port.sv
`default_nettype none
// ============================================================
// Module : tb_lsu_dmem_port
// Brief  : Scenario-driven scoreboard bench for lsu_dmem_port.
// Rev    : 1.0
// ============================================================
module tb_lsu_dmem_port;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        mem_resp_err;
  logic        done_valid;
  logic [31:0] dmem_data;
  logic        misalign;
  logic        bus_err;

  lsu_dmem_port dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err),
    .done_valid(done_valid), .dmem_data(dmem_data), .misalign(misalign), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Observations collected by run_op for the calling scenario.
  int          g_done;
  logic        g_saw_req;
  logic        g_stable;
  logic [31:0] g_addr;
  logic [31:0] g_wdata;
  logic [3:0]  g_wstrb;
  logic        g_we;
  logic [31:0] g_data;
  logic        g_mis;
  logic        g_berr;
  logic        g_pulse_after;
  logic [31:0] g_hold;
  exp_t        e;

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lane,
                                             input logic [31:0] w);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = w >> (32'(lane) * 8);
    b  = sh[7:0];
    h  = sh[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      3'b010:  return w;
      default: return 32'd0;
    endcase
  endfunction

  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input logic err, input int stall);
    int   req_cyc;
    logic resp_next;
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    g_done = -1; g_saw_req = 1'b0; g_stable = 1'b1;
    g_addr = '0; g_wdata = '0; g_wstrb = '0; g_we = 1'b0;
    g_data = 32'hXXXX_XXXX; g_mis = 1'bx; g_berr = 1'bx;
    req_cyc = 0; resp_next = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc > 0 && done_valid === 1'b1) begin
        g_done = cyc; g_data = dmem_data; g_mis = misalign; g_berr = bus_err;
        break;
      end
      if (mem_req_valid === 1'b1) begin
        if (!g_saw_req) begin
          g_addr = mem_addr; g_wdata = mem_wdata; g_wstrb = mem_wstrb; g_we = mem_we;
        end else if (mem_addr !== g_addr || mem_wdata !== g_wdata ||
                     mem_wstrb !== g_wstrb || mem_we !== g_we) begin
          g_stable = 1'b0;
        end
        g_saw_req     = 1'b1;
        mem_req_ready = (req_cyc >= stall);
        req_cyc++;
      end else begin
        mem_req_ready = 1'b0;
      end
      mem_resp_valid = resp_next;
      mem_rdata      = resp_next ? rdata : 32'hDEAD_BEEF;
      mem_resp_err   = resp_next & err;
      resp_next      = (mem_req_valid === 1'b1) && mem_req_ready;
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
    req_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
    @(posedge clk); #1;
    g_pulse_after = done_valid;
    g_hold        = dmem_data;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, done_valid, dmem_data, misalign, bus_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got req=%b we=%b addr=%h wdata=%h strb=%b done=%b data=%h mis=%b berr=%b required all zero",
               mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, done_valid, dmem_data, misalign, bus_err);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b required 1", req_ready); end
  endtask

  task automatic test_load_byte;
    sb_q.push_back('{data: 32'hFFFF_FF80, mis: 1'b0, berr: 1'b0});
    run_op(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80AA_55CC, 1'b0, 0);
    e = sb_q.pop_front();
    checks++; if (g_done !== 3) begin errors++; $display("FAIL lb_latency got %0d required 3", g_done); end
    checks++; if (g_addr !== 32'h0000_1000) begin errors++; $display("FAIL lb_addr got %h required 00001000", g_addr); end
    checks++; if (g_wstrb !== 4'b0000 || g_we !== 1'b0) begin errors++; $display("FAIL lb_strb got %b we %b required 0000 we 0", g_wstrb, g_we); end
    checks++; if (g_data !== e.data || g_mis !== e.mis || g_berr !== e.berr) begin
      errors++; $display("FAIL lb_data got %h/%b/%b required %h/%b/%b", g_data, g_mis, g_berr, e.data, e.mis, e.berr); end
    checks++; if (g_pulse_after !== 1'b0 || g_hold !== e.data) begin
      errors++; $display("FAIL lb_pulse_hold got done=%b data=%h required done=0 data=%h", g_pulse_after, g_hold, e.data); end
  endtask

  task automatic test_load_half;
    sb_q.push_back('{data: 32'h0000_BEEF, mis: 1'b0, berr: 1'b0});
    run_op(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 1'b0, 0);
    e = sb_q.pop_front();
    checks++; if (g_data !== e.data || g_mis !== e.mis || g_done !== 3) begin
      errors++; $display("FAIL lhu_data got %h/%b cyc %0d required %h/%b cyc 3", g_data, g_mis, g_done, e.data, e.mis); end
    sb_q.push_back('{data: 32'hFFFF_BEEF, mis: 1'b0, berr: 1'b0});
    run_op(1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 1'b0, 0);
    e = sb_q.pop_front();
    checks++; if (g_data !== e.data || g_mis !== e.mis) begin
      errors++; $display("FAIL lh_data got %h/%b required %h/%b", g_data, g_mis, e.data, e.mis); end
  endtask

  task automatic test_store;
    sb_q.push_back('{data: 32'h0, mis: 1'b0, berr: 1'b0});
    run_op(1'b1, 3'b000, 32'h0000_3001, 32'h0000_00A5, 32'h1111_1111, 1'b0, 0);
    e = sb_q.pop_front();
    checks++; if (g_wdata !== 32'hA5A5_A5A5 || g_wstrb !== 4'b0010 || g_we !== 1'b1 || g_addr !== 32'h0000_3000) begin
      errors++; $display("FAIL sb_bus got wdata=%h strb=%b we=%b addr=%h required a5a5a5a5/0010/1/00003000", g_wdata, g_wstrb, g_we, g_addr); end
    checks++; if (g_data !== e.data || g_mis !== e.mis || g_done !== 3) begin
      errors++; $display("FAIL sb_done got %h/%b cyc %0d required %h/%b cyc 3", g_data, g_mis, g_done, e.data, e.mis); end
    run_op(1'b1, 3'b001, 32'h0000_3002, 32'hFFFF_1234, 32'h0, 1'b0, 0);
    checks++; if (g_wdata !== 32'h1234_1234 || g_wstrb !== 4'b1100) begin
      errors++; $display("FAIL sh_bus got wdata=%h strb=%b required 12341234/1100", g_wdata, g_wstrb); end
    run_op(1'b1, 3'b010, 32'h0000_3004, 32'hCAFE_F00D, 32'h0, 1'b0, 0);
    checks++; if (g_wdata !== 32'hCAFE_F00D || g_wstrb !== 4'b1111 || g_addr !== 32'h0000_3004) begin
      errors++; $display("FAIL sw_bus got wdata=%h strb=%b addr=%h required cafef00d/1111/00003004", g_wdata, g_wstrb, g_addr); end
  endtask

  task automatic test_misalign;
    sb_q.push_back('{data: 32'h0, mis: 1'b1, berr: 1'b0});
    run_op(1'b0, 3'b010, 32'h0000_4002, 32'h0, 32'h1234_5678, 1'b0, 0);
    e = sb_q.pop_front();
    checks++; if (g_saw_req !== 1'b0 || g_done !== 1) begin
      errors++; $display("FAIL lw_mis_timing got bus=%b cyc %0d required bus=0 cyc 1", g_saw_req, g_done); end
    checks++; if (g_data !== e.data || g_mis !== e.mis || g_berr !== e.berr) begin
      errors++; $display("FAIL lw_mis_flags got %h/%b/%b required %h/%b/%b", g_data, g_mis, g_berr, e.data, e.mis, e.berr); end
    sb_q.push_back('{data: 32'h0, mis: 1'b1, berr: 1'b0});
    run_op(1'b1, 3'b100, 32'h0000_4000, 32'hFF, 32'h0, 1'b0, 0);
    e = sb_q.pop_front();
    checks++; if (g_saw_req !== 1'b0 || g_mis !== e.mis || g_done !== 1) begin
      errors++; $display("FAIL st_f3_illegal got bus=%b mis=%b cyc %0d required bus=0 mis=%b cyc 1", g_saw_req, g_mis, g_done, e.mis); end
    sb_q.push_back('{data: 32'h0, mis: 1'b1, berr: 1'b0});
    run_op(1'b0, 3'b001, 32'h0000_4001, 32'h0, 32'h0, 1'b0, 0);
    e = sb_q.pop_front();
    checks++; if (g_saw_req !== 1'b0 || g_mis !== e.mis) begin
      errors++; $display("FAIL lh_odd got bus=%b mis=%b required bus=0 mis=%b", g_saw_req, g_mis, e.mis); end
    sb_q.push_back('{data: 32'h0, mis: 1'b1, berr: 1'b0});
    run_op(1'b0, 3'b011, 32'h0000_4000, 32'h0, 32'h0, 1'b0, 0);
    e = sb_q.pop_front();
    checks++; if (g_saw_req !== 1'b0 || g_mis !== e.mis) begin
      errors++; $display("FAIL f3_011 got bus=%b mis=%b required bus=0 mis=%b", g_saw_req, g_mis, e.mis); end
  endtask

  task automatic test_stall;
    sb_q.push_back('{data: 32'h5566_7788, mis: 1'b0, berr: 1'b0});
    run_op(1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'h5566_7788, 1'b0, 3);
    e = sb_q.pop_front();
    checks++; if (g_stable !== 1'b1 || g_addr !== 32'h0000_4000) begin
      errors++; $display("FAIL stall_stable got stable=%b addr=%h required 1/00004000", g_stable, g_addr); end
    checks++; if (g_done !== 6 || g_data !== e.data || g_mis !== e.mis) begin
      errors++; $display("FAIL stall_done got cyc %0d data %h mis %b required cyc 6 data %h mis %b", g_done, g_data, g_mis, e.data, e.mis); end
  endtask

  task automatic test_bus_err;
    sb_q.push_back('{data: 32'h0, mis: 1'b0, berr: 1'b1});
    run_op(1'b0, 3'b010, 32'h0000_6000, 32'h0, 32'h1357_9BDF, 1'b1, 0);
    e = sb_q.pop_front();
    checks++; if (g_data !== e.data || g_mis !== e.mis || g_berr !== e.berr || g_done !== 3) begin
      errors++; $display("FAIL bus_err got %h/%b/%b cyc %0d required %h/%b/%b cyc 3", g_data, g_mis, g_berr, g_done, e.data, e.mis, e.berr); end
  endtask

  task automatic test_random_loads;
    logic [2:0]  f3s [5];
    logic [2:0]  f3;
    logic [1:0]  lane;
    logic [31:0] rd;
    f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 10; i++) begin
      f3   = f3s[$urandom_range(0, 4)];
      lane = 2'($urandom_range(0, 3));
      if (f3[1:0] == 2'b01) lane[0] = 1'b0;
      if (f3[1:0] == 2'b10) lane = 2'b00;
      rd = $urandom;
      sb_q.push_back('{data: model_load(f3, lane, rd), mis: 1'b0, berr: 1'b0});
      run_op(1'b0, f3, {28'h0000_700, 2'b00, lane}, 32'h0, rd, 1'b0, i % 3);
      e = sb_q.pop_front();
      checks++; if (g_data !== e.data || g_mis !== e.mis || g_berr !== e.berr) begin
        errors++; $display("FAIL rand_load f3=%b lane=%0d rdata=%h got %h required %h", f3, lane, rd, g_data, e.data); end
    end
  endtask

  task automatic test_reset_mid;
    logic seen;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_8000; req_wdata = '0;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, done_valid, dmem_data, misalign, bus_err} !== '0) begin
      errors++; $display("FAIL reset_mid_outputs got req=%b addr=%h data=%h done=%b required all zero", mem_req_valid, mem_addr, dmem_data, done_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_resp_valid = 1'b1; mem_rdata = 32'hAAAA_5555; mem_resp_err = 1'b0;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done_valid !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 1'b0 || dmem_data !== 32'h0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL stray_resp got done_seen=%b data=%h ready=%b required 0/00000000/1", seen, dmem_data, req_ready);
    end
    sb_q.push_back('{data: 32'h0BAD_F00D, mis: 1'b0, berr: 1'b0});
    run_op(1'b0, 3'b010, 32'h0000_5000, 32'h0, 32'h0BAD_F00D, 1'b0, 0);
    e = sb_q.pop_front();
    checks++; if (g_data !== e.data || g_done !== 3) begin
      errors++; $display("FAIL after_reset got %h cyc %0d required %h cyc 3", g_data, g_done, e.data); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0; mem_resp_err = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_load_byte();
    test_load_half();
    test_store();
    test_misalign();
    test_stall();
    test_bus_err();
    test_random_loads();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_dmem_port.md
Name: lsu_dmem_port

Overview:
- Load/store unit back end. Sits between execute and the data-memory bus, and produces the load data consumed by the write-back select path (DMEMData).
- Takes one load or store per transaction. Issues a single word-aligned bus request and waits for the response.
- Loads: extracts the byte/half/word and sign- or zero-extends it. Stores: replicates write data and builds byte strobes.
- Flags misaligned accesses and bus errors without issuing or completing a bus access.

Parameters:
- XLEN, 32, data and address width (fixed at 32; present for package consistency only)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  execute presents a memory op
- req_ready  out  1  block idle and able to accept
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I size/sign code
- req_addr  in  32  effective byte address
- req_wdata  in  32  store data (rs2)
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus accepts request
- mem_we  out  1  bus write
- mem_addr  out  32  word-aligned address ({req_addr[31:2],2'b00})
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte strobes (0000 for loads)
- mem_resp_valid  in  1  bus response valid
- mem_rdata  in  32  bus read word
- mem_resp_err  in  1  bus error with response
- done_valid  out  1  one-cycle completion pulse
- dmem_data  out  32  extended load result (0 for stores and errors)
- misalign  out  1  misaligned or illegal funct3, valid with done_valid
- bus_err  out  1  bus error, valid with done_valid

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=1 after release. All of the following are 0: mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, done_valid, dmem_data, misalign, bus_err.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we, funct3, addr[1:0], addr, wdata.
  - If the access is illegal, go to DONE with misalign=1 and no bus traffic. Illegal means: funct3 ∈ {011,110,111}; store funct3 ∈ {100,101}; halfword with addr[0]=1; word with addr[1:0]≠00.
  - Otherwise go to REQ.
- REQ:
  - mem_req_valid=1. mem_we, mem_addr, mem_wdata and mem_wstrb stay stable while mem_req_ready=0.
  - On mem_req_ready, go to WAIT.
  - mem_resp_valid in REQ is ignored.
- WAIT:
  - On mem_resp_valid, capture the result and go to DONE.
  - mem_resp_err=1 sets bus_err=1 and dmem_data=0.
- DONE:
  - done_valid=1 for exactly one cycle, then IDLE.
  - dmem_data, misalign and bus_err hold until the next accepted request clears them.
- Latency:
  - Zero bus stall: accept at cycle 0, REQ handshake at cycle 1, response at cycle 2, done_valid at cycle 3.
  - Misaligned request: done_valid at cycle 1.
- Load extract: lane = addr[1:0].
  - LB/LBU: byte rdata[8*lane+7 : 8*lane], sign- or zero-extended.
  - LH/LHU: half at lane 0 or 2, sign- or zero-extended.
  - LW: full word.
- Store:
  - SB: wdata={4{b}}, wstrb=0001<<lane.
  - SH: wdata={2{h}}, wstrb=0011<<lane.
  - SW: wstrb=1111.
- One outstanding transaction only; req_ready=0 in REQ/WAIT/DONE.
- Reset mid-transaction: return to IDLE immediately. A late mem_resp_valid arriving in IDLE is discarded and must not produce done_valid.

Decomposition:
- Shared package: funct3 encodings (LB..LHU, SB..SW), FSM state enum, strobe constants.
- One combinational sub-module, load_extend (rdata, lane, funct3 → extended data), reusable by any future cache path.

Test Plan:
- LB addr 0x1003, rdata 0x80AA55CC → mem_addr 0x1000, wstrb 0000, dmem_data 0xFFFFFF80, done_valid at cycle 3.
- LHU addr 0x2002, rdata 0xBEEF1234 → dmem_data 0x0000BEEF; LH same → 0xFFFFBEEF.
- SB addr 0x3001, wdata 0x000000A5 → mem_wdata 0xA5A5A5A5, mem_wstrb 0010, mem_we 1, dmem_data 0.
- LW addr 0x4002 → no mem_req_valid ever, done_valid at cycle 1, misalign 1; LW addr 0x4000 with mem_req_ready low for 3 cycles → request fields stable, done at cycle 6.
- LW, response with mem_resp_err=1 → bus_err 1, dmem_data 0, misalign 0.
- Reset asserted in WAIT, released, then a stray mem_resp_valid in IDLE → no done_valid, all outputs 0, next request completes normally.
